// File: rtl/lockout_ctrl_pkg.sv
// Shared definitions for the lock attempt/lockout controller: state encoding,
// counter widths and a saturating increment helper.
package lockout_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPEN    = 3'd1,
        ST_LOCKOUT = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ALARM   = 3'd4
    } lock_state_e;

    localparam int FAIL_W = 4;
    localparam int LOCK_W = 4;
    localparam int HOLD_W = 8;

    // Saturating +1 on a 4-bit counter; the lock counters must never wrap.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'hF) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lockout_ctrl_sec_tick.sv
// One-second tick generator: a 1-cycle pulse every CLK_HZ clocks. The divider
// restarts on clr, so the first tick after clr lands exactly CLK_HZ cycles later.
module sec_tick #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Clock divider: counts 0..CLK_HZ-1, restarted by clr.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (cnt_r == TERM) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign tick = (cnt_r == TERM) && !clr;

endmodule

// File: rtl/lockout_ctrl.sv
// Attempt/lockout controller of the digital lock. Drives the unlock actuator,
// starts the external stop_timer after MAX_FAIL consecutive wrong codes, and
// latches an alarm after ALARM_LOCKOUTS lockouts without an intervening success.
module lockout_ctrl
    import lockout_ctrl_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int MAX_FAIL       = 3,
    parameter int UNLOCK_S       = 5,
    parameter int ALARM_LOCKOUTS = 2
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       pwd_valid,
    input  logic       pwd_match,
    input  logic       relock,
    input  logic       admin_clr,
    input  logic       timer_done,
    output logic       timer_en,
    output logic       unlock,
    output logic       alarm,
    output logic [3:0] fail_cnt,
    output logic       attempt_rej
);

    localparam logic [FAIL_W-1:0] MAX_FAIL_C = FAIL_W'(MAX_FAIL);
    localparam logic [LOCK_W-1:0] ALARM_C    = LOCK_W'(ALARM_LOCKOUTS);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(UNLOCK_S - 1);

    lock_state_e       state_r;
    lock_state_e       state_nx_s;
    logic              done_meta_r;
    logic              done_sync_r;
    logic [FAIL_W-1:0] fail_cnt_r;
    logic [FAIL_W-1:0] fail_inc_s;
    logic [LOCK_W-1:0] lockout_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              hold_done_s;
    logic              open_entry_s;
    logic              tick_s;
    logic              timer_en_r;
    logic              unlock_r;
    logic              alarm_r;
    logic              attempt_rej_r;
    logic              timer_en_nx_s;
    logic              unlock_nx_s;
    logic              alarm_nx_s;
    logic              attempt_rej_nx_s;

    assign fail_inc_s   = sat_inc4(fail_cnt_r);
    assign open_entry_s = (state_nx_s == ST_OPEN) && (state_r != ST_OPEN);
    assign hold_done_s  = tick_s && (hold_cnt_r == HOLD_LAST);

    sec_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .clr     (open_entry_s),
        .tick    (tick_s)
    );

    // Two-flop synchroniser for timer_done, which comes from the 1 s clock domain.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            done_meta_r <= 1'b0;
            done_sync_r <= 1'b0;
        end else begin
            done_meta_r <= timer_done;
            done_sync_r <= done_meta_r;
        end
    end

    // State register.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pwd_valid && pwd_match) begin
                    state_nx_s = ST_OPEN;
                end else if (pwd_valid && (fail_inc_s == MAX_FAIL_C)) begin
                    state_nx_s = ST_LOCKOUT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (relock || hold_done_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (done_sync_r) begin
                    state_nx_s = ST_RELEASE;
                end else begin
                    state_nx_s = ST_LOCKOUT;
                end
            end
            ST_RELEASE: begin
                // Wait for done to fall so a stale done cannot end the next lockout.
                if (done_sync_r) begin
                    state_nx_s = ST_RELEASE;
                end else if (lockout_cnt_r == ALARM_C) begin
                    state_nx_s = ST_ALARM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (admin_clr) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ALARM;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs track the state register.
    always_comb begin
        timer_en_nx_s    = (state_nx_s == ST_LOCKOUT);
        unlock_nx_s      = (state_nx_s == ST_OPEN);
        alarm_nx_s       = (state_nx_s == ST_ALARM);
        attempt_rej_nx_s = pwd_valid && (state_r != ST_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            timer_en_r    <= 1'b0;
            unlock_r      <= 1'b0;
            alarm_r       <= 1'b0;
            attempt_rej_r <= 1'b0;
        end else begin
            timer_en_r    <= timer_en_nx_s;
            unlock_r      <= unlock_nx_s;
            alarm_r       <= alarm_nx_s;
            attempt_rej_r <= attempt_rej_nx_s;
        end
    end

    // Wrong-code and lockout counters.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt_r    <= 4'd0;
            lockout_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pwd_valid && pwd_match) begin
                        fail_cnt_r    <= 4'd0;
                        lockout_cnt_r <= 4'd0;
                    end else if (pwd_valid) begin
                        fail_cnt_r    <= fail_inc_s;
                    end else begin
                        fail_cnt_r    <= fail_cnt_r;
                    end
                end
                ST_LOCKOUT: begin
                    // Leaving LOCKOUT is the single RELEASE entry point: count it once here.
                    if (done_sync_r) begin
                        fail_cnt_r    <= 4'd0;
                        lockout_cnt_r <= sat_inc4(lockout_cnt_r);
                    end else begin
                        fail_cnt_r    <= fail_cnt_r;
                    end
                end
                ST_RELEASE: begin
                    fail_cnt_r <= 4'd0;
                end
                ST_ALARM: begin
                    if (admin_clr) begin
                        fail_cnt_r    <= 4'd0;
                        lockout_cnt_r <= 4'd0;
                    end else begin
                        fail_cnt_r    <= fail_cnt_r;
                    end
                end
                default: begin
                    fail_cnt_r <= fail_cnt_r;
                end
            endcase
        end
    end

    // Unlock hold counter: seconds spent in OPEN, restarted on every entry.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else if (open_entry_s) begin
            hold_cnt_r <= 8'd0;
        end else if ((state_r == ST_OPEN) && tick_s && (hold_cnt_r != 8'hFF)) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    assign timer_en    = timer_en_r;
    assign unlock      = unlock_r;
    assign alarm       = alarm_r;
    assign fail_cnt    = fail_cnt_r;
    assign attempt_rej = attempt_rej_r;

endmodule

// File: tb/tb_lockout_ctrl.sv
// Bench for lockout_ctrl with a 10 Hz "second" and a stop_timer model that
// raises done N_DONE cycles after EN and clears it as soon as EN drops.
module tb_lockout_ctrl;

    localparam int CLK_HZ = 10;
    localparam int N_DONE = 4;

    logic       clk_50m = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwd_valid = 1'b0;
    logic       pwd_match = 1'b0;
    logic       relock = 1'b0;
    logic       admin_clr = 1'b0;
    logic       timer_done;
    logic       timer_en;
    logic       unlock;
    logic       alarm;
    logic [3:0] fail_cnt;
    logic       attempt_rej;

    int checks = 0;
    int failures = 0;

    lockout_ctrl #(
        .CLK_HZ         (CLK_HZ),
        .MAX_FAIL       (3),
        .UNLOCK_S       (5),
        .ALARM_LOCKOUTS (2)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .pwd_valid   (pwd_valid),
        .pwd_match   (pwd_match),
        .relock      (relock),
        .admin_clr   (admin_clr),
        .timer_done  (timer_done),
        .timer_en    (timer_en),
        .unlock      (unlock),
        .alarm       (alarm),
        .fail_cnt    (fail_cnt),
        .attempt_rej (attempt_rej)
    );

    always #5 clk_50m = ~clk_50m;

    // stop_timer model
    logic [3:0] st_cnt = 4'd0;
    always @(posedge clk_50m) begin
        if (!timer_en) st_cnt <= 4'd0;
        else if (st_cnt != 4'(N_DONE)) st_cnt <= st_cnt + 4'd1;
    end
    assign timer_done = timer_en && (st_cnt == 4'(N_DONE));

    typedef struct {
        logic       pv;
        logic       pm;
        logic       rl;
        logic       ac;
        logic       unl;
        logic       alm;
        logic       ten;
        logic       rej;
        logic [3:0] fc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic code(input logic match);
        pwd_valid = 1'b1;
        pwd_match = match;
        step();
        pwd_valid = 1'b0;
        pwd_match = 1'b0;
    endtask

    task automatic wait_done_then_release(input string tag, output int lat);
        int k;
        k = 0;
        while (!timer_done && k < 50) begin
            step();
            k++;
        end
        chk({tag, "_done_seen"}, int'(timer_done), 1);
        lat = 0;
        while (timer_en && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //            pv    pm    rl    ac    unl   alm   ten   rej   fc
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        // reset values
        step();
        step();
        chk("rst_timer_en", int'(timer_en), 0);
        chk("rst_unlock", int'(unlock), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        chk("rst_attempt_rej", int'(attempt_rej), 0);
        rst_n = 1'b1;
        step();

        // table-driven single-cycle behaviour
        for (int i = 0; i < 12; i++) begin
            pwd_valid = tbl[i].pv;
            pwd_match = tbl[i].pm;
            relock    = tbl[i].rl;
            admin_clr = tbl[i].ac;
            step();
            chk($sformatf("vec%0d_unlock", i), int'(unlock), int'(tbl[i].unl));
            chk($sformatf("vec%0d_alarm", i), int'(alarm), int'(tbl[i].alm));
            chk($sformatf("vec%0d_timer_en", i), int'(timer_en), int'(tbl[i].ten));
            chk($sformatf("vec%0d_rej", i), int'(attempt_rej), int'(tbl[i].rej));
            chk($sformatf("vec%0d_fail_cnt", i), int'(fail_cnt), int'(tbl[i].fc));
        end
        pwd_valid = 1'b0;
        pwd_match = 1'b0;
        relock    = 1'b0;
        admin_clr = 1'b0;

        // 1: correct code, unlock held for UNLOCK_S * CLK_HZ cycles
        code(1'b1);
        chk("t1_unlock_rise", int'(unlock), 1);
        n = 0;
        while (unlock && n < 100) begin
            step();
            n++;
        end
        chk("t1_unlock_cycles", n, 50);
        chk("t1_fail_cnt", int'(fail_cnt), 0);

        // 2+3: three wrong codes, reject during LOCKOUT/RELEASE, done latency
        code(1'b0);
        chk("t2_fail1", int'(fail_cnt), 1);
        code(1'b0);
        chk("t2_fail2", int'(fail_cnt), 2);
        code(1'b0);
        chk("t2_fail3", int'(fail_cnt), 3);
        chk("t2_timer_en", int'(timer_en), 1);
        code(1'b1);
        chk("t3_rej_lockout", int'(attempt_rej), 1);
        chk("t3_fail_hold", int'(fail_cnt), 3);
        chk("t3_unlock_low", int'(unlock), 0);
        step();
        chk("t3_rej_pulse_end", int'(attempt_rej), 0);
        wait_done_then_release("t2", n);
        chk("t2_en_fall_latency", n, 3);
        chk("t2_fail_cleared", int'(fail_cnt), 0);
        code(1'b0);
        chk("t3_rej_release", int'(attempt_rej), 1);
        chk("t3_fail_release", int'(fail_cnt), 0);
        repeat (3) step();
        code(1'b0);
        chk("t2_back_idle_fail", int'(fail_cnt), 1);
        chk("t2_back_idle_rej", int'(attempt_rej), 0);

        // 4: second lockout without success -> latched alarm
        code(1'b0);
        code(1'b0);
        chk("t4_timer_en", int'(timer_en), 1);
        wait_done_then_release("t4", n);
        chk("t4_en_fall_latency", n, 3);
        n = 0;
        while (!alarm && n < 20) begin
            step();
            n++;
        end
        chk("t4_alarm", int'(alarm), 1);
        chk("t4_alarm_timer_en", int'(timer_en), 0);
        code(1'b1);
        chk("t4_rej_alarm", int'(attempt_rej), 1);
        chk("t4_no_unlock", int'(unlock), 0);
        repeat (10) step();
        chk("t4_alarm_latched", int'(alarm), 1);
        chk("t4_fail_zero", int'(fail_cnt), 0);
        admin_clr = 1'b1;
        step();
        admin_clr = 1'b0;
        chk("t4_alarm_cleared", int'(alarm), 0);
        // lockout count was cleared: one more lockout must not alarm
        code(1'b0);
        code(1'b0);
        code(1'b0);
        wait_done_then_release("t4b", n);
        repeat (6) step();
        chk("t4_no_alarm_after_clr", int'(alarm), 0);
        chk("t4_idle_after_clr", int'(timer_en), 0);

        // 5: relock coincident with the 2nd one-second tick
        code(1'b1);
        chk("t5_unlock", int'(unlock), 1);
        repeat (19) step();
        chk("t5_unlock_before_relock", int'(unlock), 1);
        relock = 1'b1;
        step();
        relock = 1'b0;
        chk("t5_relock_unlock", int'(unlock), 0);
        repeat (12) step();
        chk("t5_stays_closed", int'(unlock), 0);
        chk("t5_no_rej", int'(attempt_rej), 0);

        // 6: reset mid-lockout is asynchronous
        code(1'b0);
        code(1'b0);
        code(1'b0);
        chk("t6_timer_en", int'(timer_en), 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_timer_en", int'(timer_en), 0);
        chk("t6_rst_fail_cnt", int'(fail_cnt), 0);
        chk("t6_rst_unlock", int'(unlock), 0);
        chk("t6_rst_alarm", int'(alarm), 0);
        #2;
        rst_n = 1'b1;
        step();
        step();
        code(1'b0);
        chk("t6_idle_after_rst", int'(fail_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
